// File: rtl/demux_stream_param_pkg.sv
// Shared definitions for the registered stream demultiplexer.
// Provides the routing-mode encodings carried on the 2-bit `mode` input.
package demux_stream_param_pkg;

  typedef enum logic [1:0] {
    DMX_UNICAST   = 2'b00,
    DMX_BROADCAST = 2'b01,
    DMX_MULTICAST = 2'b10,
    DMX_RESERVED  = 2'b11
  } dmx_mode_e;

endpackage : demux_stream_param_pkg

// File: rtl/demux_slot.sv
// One output lane of the demultiplexer: a single-word valid/ready holding slot.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - write load_data into the slot this cycle
//   load_data  - word to store
//   out_ready  - consumer ready for this lane
//   out_valid  - slot full
//   data_out   - stored word (held after drain; qualify with out_valid)
//   can_load   - slot is empty or drains this cycle, so a load is safe
module demux_slot #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  can_load
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign data_out  = data_q;

  // A load in the same cycle as a drain wins, so the slot stays full with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule : demux_slot

// File: rtl/demux_stream_param.sv
// Registered, flow-controlled 1-to-N demultiplexer.
// Each accepted word is written to one lane (unicast), all lanes (broadcast) or a masked set
// (multicast). Acceptance is all-or-nothing across the targeted lanes.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid / in_ready  - input handshake; in_ready does not depend on in_valid
//   data_in              - input word
//   sel, mode, mask      - route: unicast lane, routing mode, multicast lane set
//   out_valid/out_ready  - per-lane handshake
//   data_out             - lane i at data_out[i*DATA_WIDTH +: DATA_WIDTH]
//   err                  - one-cycle pulse for an accepted word dropped on an illegal route
module demux_stream_param
  import demux_stream_param_pkg::*;
#(
  parameter int unsigned NUM_OUTPUT = 8,
  parameter int unsigned SEL_WIDTH  = 3,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [SEL_WIDTH-1:0]             sel,
  input  logic [1:0]                       mode,
  input  logic [NUM_OUTPUT-1:0]            mask,
  output logic [NUM_OUTPUT-1:0]            out_valid,
  input  logic [NUM_OUTPUT-1:0]            out_ready,
  output logic [DATA_WIDTH*NUM_OUTPUT-1:0] data_out,
  output logic                             err
);

  logic [NUM_OUTPUT-1:0] target;
  logic [NUM_OUTPUT-1:0] can_load;
  logic                  illegal;
  logic                  accept;
  logic                  err_q;

  // Target decode. An empty target means the word is consumed and dropped.
  always_comb begin
    target  = '0;
    illegal = 1'b0;
    unique case (mode)
      DMX_UNICAST: begin
        for (int unsigned i = 0; i < NUM_OUTPUT; i++) begin
          if (32'(sel) == i) target[i] = 1'b1;
        end
        illegal = (32'(sel) >= NUM_OUTPUT);
      end
      DMX_BROADCAST: target = '1;
      DMX_MULTICAST: target = mask;
      DMX_RESERVED:  illegal = 1'b1;
      default:       illegal = 1'b1;
    endcase
  end

  // Untargeted lanes never block; an empty target is always ready.
  assign in_ready = &(~target | can_load);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && illegal;
    end
  end

  assign err = err_q;

  for (genvar g = 0; g < NUM_OUTPUT; g++) begin : g_lane
    demux_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && target[g]),
      .load_data(data_in),
      .out_ready(out_ready[g]),
      .out_valid(out_valid[g]),
      .data_out (data_out[g*DATA_WIDTH +: DATA_WIDTH]),
      .can_load (can_load[g])
    );
  end

endmodule : demux_stream_param

// File: tb/tb_demux_stream_param.sv
module tb_demux_stream_param;

  localparam int N  = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic [2:0]    sel;
  logic [1:0]    mode;
  logic [N-1:0]  mask;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [DW*N-1:0] data_out;
  logic          err;

  // Second instance with 6 lanes so that sel = 6, 7 are illegal.
  logic          b_in_valid;
  logic          b_in_ready;
  logic [DW-1:0] b_data_in;
  logic [2:0]    b_sel;
  logic [1:0]    b_mode;
  logic [5:0]    b_mask;
  logic [5:0]    b_out_valid;
  logic [5:0]    b_out_ready;
  logic [DW*6-1:0] b_data_out;
  logic          b_err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit            m_valid[N];
  logic [DW-1:0] m_data[N];
  bit            m_err;
  bit            last_stall;

  always #5 clk = ~clk;

  demux_stream_param #(.NUM_OUTPUT(8), .SEL_WIDTH(3), .DATA_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .sel(sel), .mode(mode), .mask(mask), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err(err)
  );

  demux_stream_param #(.NUM_OUTPUT(6), .SEL_WIDTH(3), .DATA_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
    .sel(b_sel), .mode(b_mode), .mask(b_mask), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .data_out(b_data_out), .err(b_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_err      = 1'b0;
    last_stall = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0]    ev;
    logic [DW*N-1:0] ed;
    for (int i = 0; i < N; i++) begin
      ev[i]          = m_valid[i];
      ed[i*DW +: DW] = m_data[i];
    end
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".data_out"}, 64'(data_out), 64'(ed));
    check({tag, ".err"}, 64'(err), 64'(m_err));
  endtask

  // Entered and left one time unit after a rising edge, with inputs already driven.
  task automatic step(input string tag);
    logic [N-1:0] t;
    bit ill, rdy, acc;
    t   = '0;
    ill = 1'b0;
    case (mode)
      2'b00: if (int'(sel) < N) t[sel] = 1'b1; else ill = 1'b1;
      2'b01: t = '1;
      2'b10: t = mask;
      default: ill = 1'b1;
    endcase
    rdy = 1'b1;
    for (int i = 0; i < N; i++) if (t[i] && m_valid[i] && !out_ready[i]) rdy = 1'b0;
    #3;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    acc        = in_valid && rdy;
    last_stall = in_valid && !rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc && t[i]) begin
        m_valid[i] = 1'b1;
        m_data[i]  = data_in;
      end else if (m_valid[i] && out_ready[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    m_err = acc && ill;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.data_out", 64'(data_out), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; data_in = '0; sel = '0; mode = 2'b00; mask = '0; out_ready = '0;
    b_in_valid = 1'b0; b_data_in = '0; b_sel = '0; b_mode = 2'b00; b_mask = '0;
    b_out_ready = '1;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Unicast stream over every lane.
    out_ready = '1;
    in_valid  = 1'b1;
    mode      = 2'b00;
    for (int i = 0; i < N; i++) begin
      sel     = 3'(i);
      data_in = 4'(i + 1);
      step("uni");
      check("uni.onehot", 64'($countones(out_valid)), 64'd1);
      check("uni.lane", 64'(data_out[i*DW +: DW]), 64'(i + 1));
    end
    in_valid = 1'b0;
    step("uni.drain");

    // Broadcast blocked by a stalled full lane 5.
    out_ready = 8'hDF;
    in_valid  = 1'b1; mode = 2'b00; sel = 3'd5; data_in = 4'h5;
    step("bc.fill5");
    mode = 2'b01; data_in = 4'hA;
    step("bc.blocked");
    check("bc.blocked_ready", 64'(in_ready), 64'd0);
    out_ready = '1;
    step("bc.accept");
    check("bc.all_valid", 64'(out_valid), 64'hFF);
    check("bc.all_data", 64'(data_out), 64'hAAAA_AAAA);
    in_valid = 1'b0; out_ready = '0;
    step("bc.hold");

    // Multicast to lanes 0, 5, 7 while every lane is full and stalled.
    in_valid = 1'b1; mode = 2'b10; mask = 8'b1010_0001; data_in = 4'h6;
    step("mc.blocked");
    out_ready = 8'b1010_0001;
    step("mc.accept");
    check("mc.data", 64'(data_out), 64'h6A6A_AAA6);
    in_valid = 1'b0; out_ready = '1;
    step("mc.drain");

    // Reserved mode and empty multicast, back to back.
    in_valid = 1'b1; mode = 2'b11; data_in = 4'hF;
    step("rsv.1");
    step("rsv.2");
    mode = 2'b10; mask = '0;
    step("mc0");
    in_valid = 1'b0;
    step("idle");

    // Full slot with simultaneous drain and load.
    out_ready = '0;
    in_valid = 1'b1; mode = 2'b00; sel = 3'd2; data_in = 4'h3;
    step("pt.fill");
    out_ready = 8'h04; data_in = 4'h4;
    step("pt.swap");
    check("pt.lane2", 64'(data_out[2*DW +: DW]), 64'h4);
    check("pt.valid2", 64'(out_valid[2]), 64'd1);
    in_valid = 1'b0; out_ready = '1;
    step("pt.drain");

    // Reset with lanes 1 and 4 full, then an immediate unicast.
    out_ready = '0;
    in_valid = 1'b1; mode = 2'b10; mask = 8'b0001_0010; data_in = 4'h7;
    step("rm.fill");
    do_reset();
    in_valid = 1'b1; mode = 2'b00; sel = 3'd3; data_in = 4'h9;
    step("rm.first");

    // Random traffic; route and data are held while a word is stalled.
    for (int n = 0; n < 400; n++) begin
      out_ready = 8'($urandom);
      if (!last_stall) begin
        in_valid = ($urandom_range(3, 0) != 0);
        data_in  = 4'($urandom);
        sel      = 3'($urandom);
        mode     = ($urandom_range(9, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
        mask     = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom);
      end
      step("rnd");
    end
    in_valid = 1'b0; out_ready = '1;
    step("rnd.drain");

    // Six-lane instance: illegal select and reserved mode.
    b_in_valid = 1'b1; b_mode = 2'b00; b_sel = 3'd7; b_data_in = 4'hC;
    #3;
    check("b.sel7.ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    check("b.sel7.err", 64'(b_err), 64'd1);
    check("b.sel7.valid", 64'(b_out_valid), 64'd0);
    b_mode = 2'b11;
    #3;
    check("b.rsv.ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    check("b.rsv.err", 64'(b_err), 64'd1);
    check("b.rsv.valid", 64'(b_out_valid), 64'd0);
    b_mode = 2'b10; b_mask = '0;
    @(posedge clk); #1;
    check("b.mc0.err", 64'(b_err), 64'd0);
    check("b.mc0.valid", 64'(b_out_valid), 64'd0);
    b_mode = 2'b00; b_sel = 3'd5; b_data_in = 4'h7;
    @(posedge clk); #1;
    check("b.sel5.err", 64'(b_err), 64'd0);
    check("b.sel5.valid", 64'(b_out_valid), 64'h20);
    check("b.sel5.data", 64'(b_data_out[5*DW +: DW]), 64'h7);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    check("b.idle.valid", 64'(b_out_valid), 64'd0);
    check("b.idle.err", 64'(b_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_stream_param
